alu_stream_q: RTL and testbench

Parametrised successor to the single-operation `top_pipe` arithmetic unit. It accepts a stream of tagged two-operand operations over a valid/ready handshake and executes single-cycle ALU ops at one per cycle. Multiply runs on an iterative shift-add engine. Results, flags and tags are returned in order through an internal result FIFO with its own valid/ready handshake. It sits between the command sequencer and the writeback stage, and replaces the enable/done pulse protocol.

---
 rtl/alu_stream_pkg.sv | 24 ++
 rtl/result_fifo.sv | 53 +++++
 rtl/alu_stream_q.sv | 178 +++++++++++++++++
 tb/tb_alu_stream_q.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_stream_pkg.sv
// Shared constants for the streaming ALU: mode encodings, flag bit positions
// and the multiply-engine FSM state encoding.
package alu_stream_pkg;

  localparam logic [2:0] MODE_ADD = 3'd0;
  localparam logic [2:0] MODE_SUB = 3'd1;
  localparam logic [2:0] MODE_MUL = 3'd2;
  localparam logic [2:0] MODE_AND = 3'd3;
  localparam logic [2:0] MODE_OR  = 3'd4;
  localparam logic [2:0] MODE_XOR = 3'd5;
  localparam logic [2:0] MODE_SLL = 3'd6;
  localparam logic [2:0] MODE_SRA = 3'd7;

  localparam int unsigned FLG_ZERO  = 0;
  localparam int unsigned FLG_CARRY = 1;
  localparam int unsigned FLG_OVF   = 2;
  localparam int unsigned FLAG_W    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/result_fifo.sv
// First-word-fall-through result FIFO.
// Ports: clk/rst (async active-high), push_i/data_i write side,
// pop_i/data_o/valid_o read side (head visible whenever valid_o),
// count_o current occupancy. The head reads as zero while empty.
module result_fifo #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [DW-1:0]            data_i,
  input  logic                     pop_i,
  output logic [DW-1:0]            data_o,
  output logic                     valid_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [CW-1:0] count_q;
  logic          full_c, do_push_c, do_pop_c;

  assign valid_o   = (count_q != '0);
  assign full_c    = (count_q == CW'(DEPTH));
  assign do_pop_c  = pop_i & valid_o;
  // A push into a full FIFO is only legal when the head leaves on the same edge
  assign do_push_c = push_i & (~full_c | do_pop_c);
  assign data_o    = valid_o ? mem_q[rd_q] : '0;
  assign count_o   = count_q;

  // Pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push_c) wr_q <= wr_q + AW'(1);
      if (do_pop_c)  rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push_c) - CW'(do_pop_c);
    end
  end

  // Storage; contents are never observed while empty, so no reset needed
  always_ff @(posedge clk) begin
    if (do_push_c) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/alu_stream_q.sv
// Streaming tagged ALU with iterative shift-add multiplier and in-order
// result FIFO.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_mode/in_op1/
// in_op2/in_tag operation input; out_valid/out_ready/out_result/out_tag/
// out_flags ({ovf,carry,zero}) result output; busy = MUL running or
// execute register occupied.
module alu_stream_q
  import alu_stream_pkg::*;
#(
  parameter int unsigned WIDTH      = 64,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TAG_W      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_mode,
  input  logic [WIDTH-1:0]  in_op1,
  input  logic [WIDTH-1:0]  in_op2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic [2:0]        out_flags,
  output logic              busy
);

  localparam int unsigned SH_W  = $clog2(WIDTH);
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DW    = WIDTH + TAG_W + FLAG_W;

  state_e               state_q, state_d;
  logic                 exec_valid_q;
  logic [2:0]           exec_mode_q;
  logic [WIDTH-1:0]     exec_op1_q, exec_op2_q;
  logic [TAG_W-1:0]     exec_tag_q;
  logic [2*WIDTH-1:0]   mcand_q, prod_q;
  logic [WIDTH-1:0]     mplier_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [TAG_W-1:0]     mul_tag_q;
  logic [CW-1:0]        fifo_count;
  logic                 credit_c, accept_c, accept_mul_c, accept_alu_c;
  logic                 mul_done_c, push_c, pop_c;
  logic [WIDTH:0]       sum_c, diff_c;
  logic [WIDTH-1:0]     alu_res_c;
  logic [FLAG_W-1:0]    alu_flg_c, mul_flg_c;
  logic [DW-1:0]        push_data_c, head_c;

  // Reserve a FIFO slot for the op sitting in the execute register
  assign credit_c = (({1'b0, fifo_count} + (CW+1)'(exec_valid_q)) < (CW+1)'(FIFO_DEPTH));
  // MUL must wait until the execute register has drained to keep ordering
  assign in_ready = (state_q == ST_IDLE) & credit_c & ~((in_mode == MODE_MUL) & exec_valid_q);
  assign accept_c     = in_valid & in_ready;
  assign accept_mul_c = accept_c & (in_mode == MODE_MUL);
  assign accept_alu_c = accept_c & (in_mode != MODE_MUL);
  // WIDTH iterations done; the push edge follows them
  assign mul_done_c   = (state_q == ST_MUL) & (cnt_q == CNT_W'(WIDTH));
  assign busy         = (state_q == ST_MUL) | exec_valid_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept_mul_c) state_d = ST_MUL;
      ST_MUL:  if (mul_done_c)   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Execute register for single-cycle ops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_valid_q <= 1'b0;
      exec_mode_q  <= '0;
      exec_op1_q   <= '0;
      exec_op2_q   <= '0;
      exec_tag_q   <= '0;
    end else begin
      exec_valid_q <= accept_alu_c;
      if (accept_alu_c) begin
        exec_mode_q <= in_mode;
        exec_op1_q  <= in_op1;
        exec_op2_q  <= in_op2;
        exec_tag_q  <= in_tag;
      end
    end
  end

  // Shift-add multiplier: one partial product per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      cnt_q     <= '0;
      mul_tag_q <= '0;
    end else if (accept_mul_c) begin
      mcand_q   <= (2*WIDTH)'(in_op1);
      mplier_q  <= in_op2;
      prod_q    <= '0;
      cnt_q     <= '0;
      mul_tag_q <= in_tag;
    end else if ((state_q == ST_MUL) && !mul_done_c) begin
      prod_q   <= prod_q + (mplier_q[0] ? mcand_q : '0);
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  assign sum_c  = {1'b0, exec_op1_q} + {1'b0, exec_op2_q};
  assign diff_c = {1'b0, exec_op1_q} - {1'b0, exec_op2_q};

  // Single-cycle ALU on the execute register
  always_comb begin
    alu_res_c = '0;
    alu_flg_c = '0;
    case (exec_mode_q)
      MODE_ADD: begin
        alu_res_c            = sum_c[WIDTH-1:0];
        alu_flg_c[FLG_CARRY] = sum_c[WIDTH];
        alu_flg_c[FLG_OVF]   = (exec_op1_q[WIDTH-1] == exec_op2_q[WIDTH-1]) &&
                               (sum_c[WIDTH-1] != exec_op1_q[WIDTH-1]);
      end
      MODE_SUB: begin
        alu_res_c            = diff_c[WIDTH-1:0];
        alu_flg_c[FLG_CARRY] = diff_c[WIDTH];
        alu_flg_c[FLG_OVF]   = (exec_op1_q[WIDTH-1] != exec_op2_q[WIDTH-1]) &&
                               (diff_c[WIDTH-1] != exec_op1_q[WIDTH-1]);
      end
      MODE_AND: alu_res_c = exec_op1_q & exec_op2_q;
      MODE_OR:  alu_res_c = exec_op1_q | exec_op2_q;
      MODE_XOR: alu_res_c = exec_op1_q ^ exec_op2_q;
      MODE_SLL: alu_res_c = exec_op1_q << exec_op2_q[SH_W-1:0];
      MODE_SRA: alu_res_c = WIDTH'($signed(exec_op1_q) >>> exec_op2_q[SH_W-1:0]);
      default:  alu_res_c = '0;
    endcase
    alu_flg_c[FLG_ZERO] = (alu_res_c == '0);
  end

  always_comb begin
    mul_flg_c           = '0;
    mul_flg_c[FLG_ZERO] = (prod_q[WIDTH-1:0] == '0);
    mul_flg_c[FLG_OVF]  = (prod_q[2*WIDTH-1:WIDTH] != '0);
  end

  // Exec and MUL pushes are mutually exclusive by the acceptance rules
  assign push_c      = exec_valid_q | mul_done_c;
  assign push_data_c = mul_done_c ? {prod_q[WIDTH-1:0], mul_tag_q, mul_flg_c}
                                  : {alu_res_c, exec_tag_q, alu_flg_c};
  assign pop_c       = out_valid & out_ready;

  result_fifo #(
    .DW    (DW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .data_i  (push_data_c),
    .pop_i   (pop_c),
    .data_o  (head_c),
    .valid_o (out_valid),
    .count_o (fifo_count)
  );

  assign {out_result, out_tag, out_flags} = head_c;

endmodule

// File: tb/tb_alu_stream_q.sv
module tb_alu_stream_q;

  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    in_mode;
  logic [W-1:0]  in_op1, in_op2;
  logic [3:0]    in_tag;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_result;
  logic [3:0]    out_tag;
  logic [2:0]    out_flags;
  logic          busy;

  alu_stream_q #(.WIDTH(64), .FIFO_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_op1(in_op1), .in_op2(in_op2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_flags(out_flags), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  tag;
    logic [2:0]  flg;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   passed = 0;
  int   cyc = 0;
  int   n_acc = 0;
  bit   done5 = 0;
  bit   rnd_on = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain wide arithmetic on the mode definitions
  function automatic exp_t model(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                                 input logic [3:0] t);
    exp_t e;
    logic [64:0]         s;
    logic [127:0]        p;
    logic signed [65:0]  sa, sb, ss;
    logic signed [65:0]  smax, smin;
    int                  amt;
    logic c, v;
    smax = 66'sd9223372036854775807;
    smin = -smax - 66'sd1;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    amt = int'(b % 64);
    c = 1'b0; v = 1'b0;
    case (m)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; e.res = s[63:0]; c = s[64];
                  ss = sa + sb; v = (ss > smax) || (ss < smin); end
      3'd1: begin e.res = a - b; c = (a < b); ss = sa - sb; v = (ss > smax) || (ss < smin); end
      3'd2: begin p = {64'd0, a} * {64'd0, b}; e.res = p[63:0]; v = (p >= (128'd1 << 64)); end
      3'd3: e.res = a & b;
      3'd4: e.res = a | b;
      3'd5: e.res = a ^ b;
      3'd6: e.res = a << amt;
      default: e.res = 64'($signed(a) >>> amt);
    endcase
    e.tag = t;
    e.flg = {v, c, (e.res == 64'd0)};
    return e;
  endfunction

  // Acceptance monitor: record expected response for every accepted op
  always @(posedge clk) begin
    if (rst) expq.delete();
    else if (in_valid && in_ready) begin
      expq.push_back(model(in_mode, in_op1, in_op2, in_tag));
      n_acc++;
    end
  end

  // Output monitor: compare each popped head, and head stability under stall
  exp_t held;
  bit   held_v = 0;
  always @(negedge clk) begin
    exp_t e;
    if (rst) held_v = 0;
    else begin
      if (held_v) chk("hold_stable", {out_valid, out_result, out_tag, out_flags}, {1'b1, held});
      held_v = 0;
      if (out_valid && !out_ready) begin
        held = {out_result, out_tag, out_flags};
        held_v = 1;
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) chk("unexpected_output", {out_result, out_tag, out_flags}, 128'd0);
        else begin
          e = expq.pop_front();
          chk("result", {out_result, out_tag, out_flags}, e);
        end
      end
    end
  end

  // Offer one op; returns the cycle of the accepting edge
  task automatic drive(input logic [2:0] m, input logic [63:0] a, input logic [63:0] b,
                       input logic [3:0] t, output int k);
    in_valid = 1'b1; in_mode = m; in_op1 = a; in_op2 = b; in_tag = t;
    k = -1;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        k = cyc;
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    chk("accept_timeout", 128'd0, 128'd1);
  endtask

  task automatic wait_out(output int n);
    n = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin n = i; return; end
    end
    chk("out_timeout", 128'd0, 128'd1);
  endtask

  function automatic logic [63:0] rnd_op();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = '1;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k0, n, bad, stale, n0;
    logic [2:0] modes [8];
    modes = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    rst = 1'b1; in_valid = 1'b0; in_mode = '0; in_op1 = '0; in_op2 = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid2", 128'(out_valid), 128'd0);
    chk("rst_out_fields", {out_result, out_tag, out_flags}, 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);

    // ADD carry-out wrap to zero, first-transaction latency
    drive(3'd0, '1, 64'd1, 4'd3, k);
    chk("add_valid_k", 128'(out_valid), 128'd0);
    @(posedge clk); #1;
    chk("add_valid_k1", 128'(out_valid), 128'd1);
    chk("add_head", {out_result, out_tag, out_flags}, {64'd0, 4'd3, 3'b011});
    repeat (3) @(posedge clk); #1;

    // Back-to-back single-cycle ops
    for (int i = 0; i < 8; i++) begin
      k0 = k;
      drive(modes[i], {$urandom, $urandom}, {$urandom, $urandom}, 4'(i), k);
      if (i > 0) chk("b2b_gap", 128'(k - k0), 128'd1);
    end
    repeat (4) @(posedge clk); #1;

    // MUL with overflow, following ADD held off
    drive(3'd2, 64'h1_0000_0000, 64'h1_0000_0000, 4'd5, k);
    in_valid = 1'b1; in_mode = 3'd0; in_op1 = 64'd7; in_op2 = 64'd8; in_tag = 4'd6;
    bad = 0; n = -1;
    for (int i = 1; i <= 80; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin n = cyc - k; break; end
      if (in_ready || !busy) bad++;
    end
    chk("mul_latency", 128'(n), 128'd65);
    chk("mul_ready_low", 128'(bad), 128'd0);
    chk("mul_head", {out_result, out_tag, out_flags}, {64'd0, 4'd5, 3'b101});
    @(negedge clk);
    chk("mul_release", 128'(in_ready), 128'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk); #1;

    // Backpressure: credit stops at FIFO depth
    out_ready = 1'b0;
    n0 = n_acc;
    fork
      begin
        int kk;
        for (int i = 0; i < 5; i++) drive(3'd0, {$urandom, $urandom}, {$urandom, $urandom}, 4'(8 + i), kk);
        done5 = 1;
      end
    join_none
    repeat (12) @(posedge clk); #1;
    chk("bp_in_ready", 128'(in_ready), 128'd0);
    chk("bp_accepted", 128'(n_acc - n0), 128'd4);
    chk("bp_out_valid", 128'(out_valid), 128'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done5; i++) @(posedge clk);
    #1;
    chk("bp_fifth", 128'(done5), 128'd1);
    repeat (6) @(posedge clk); #1;

    // Shift and subtract boundaries
    drive(3'd7, 64'h8000_0000_0000_0000, 64'd63, 4'd1, k);
    wait_out(n);
    chk("sra_63", 128'(out_result), 128'(64'hFFFF_FFFF_FFFF_FFFF));
    repeat (2) @(posedge clk); #1;
    drive(3'd6, 64'd1, 64'd64, 4'd2, k);
    wait_out(n);
    chk("sll_amt0", 128'(out_result), 128'd1);
    repeat (2) @(posedge clk); #1;
    drive(3'd1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 4'd4, k);
    wait_out(n);
    chk("sub_equal_flags", 128'(out_flags), 128'b001);
    repeat (2) @(posedge clk); #1;

    // Reset mid-MUL with queued results
    out_ready = 1'b0;
    drive(3'd0, 64'd1, 64'd2, 4'd1, k);
    drive(3'd4, 64'd1, 64'd2, 4'd2, k);
    drive(3'd2, 64'd3, 64'd5, 4'd3, k);
    repeat (10) @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("rst_mid_out_valid", 128'(out_valid), 128'd0);
    chk("rst_mid_in_ready", 128'(in_ready), 128'd1);
    chk("rst_mid_busy", 128'(busy), 128'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("rst_no_stale", 128'(stale), 128'd0);

    // Randomized traffic with random backpressure
    rnd_on = 1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      drive(3'($urandom_range(0, 7)), rnd_op(), rnd_op(), 4'($urandom_range(0, 15)), k);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
    rnd_on = 0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    for (int i = 0; i < 200 && (expq.size() != 0); i++) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", 128'(expq.size()), 128'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
